// File: rtl/rgb_pwm_ctrl.sv
// rgb_pwm_ctrl: power sequencer and PWM generator for the three-channel RGB
// LED current-sink driver. Brings up the driver bias, holds for a settle
// interval, then gates each channel with an 8-bit frame-compare PWM. Duty and
// current codes are shadowed so they only change at frame boundaries while
// the LEDs are lit.
//
// Ports:
//   clk                 block clock
//   rst_n               synchronous active-low reset
//   wr_en/wr_addr/wr_data  single-cycle register write port (write-only bank)
//   rgbled_en           driver bias enable
//   cbit_rgb_en         bias current-path enable
//   rgb_pwm[2:0]        per-channel PWM gate, bit N gates cbit_rgbN
//   cbit_rgb0/1/2       6-bit current-select codes
//   ready               high only while in RUN
//   state               OFF=00, SETTLE=01, RUN=10, DRAIN=11
//
// Register map: 0x0 CTRL (bit0 led_on), 0x1 PRESC, 0x2-0x4 DUTY0..2,
//               0x5-0x7 CUR0..2 (bits 5:0). Other addresses are ignored.
//
// state  | meaning
// -------+-----------------------------------------------------------
// OFF    | bias and PWM off, shadows track registers
// SETTLE | bias on, PWM held low while the bias settles
// RUN    | bias on, PWM running, shadows reload at frame boundaries
// DRAIN  | led_on dropped, PWM finishes the current frame, then OFF

module rgb_pwm_ctrl #(
   parameter int SETTLE_CYCLES = 64,
   parameter int PRESC_W       = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         wr_en,
   input  logic [3:0]   wr_addr,
   input  logic [7:0]   wr_data,
   output logic         rgbled_en,
   output logic         cbit_rgb_en,
   output logic [2:0]   rgb_pwm,
   output logic [5:0]   cbit_rgb0,
   output logic [5:0]   cbit_rgb1,
   output logic [5:0]   cbit_rgb2,
   output logic         ready,
   output logic [1:0]   state
);

   typedef enum logic [1:0] {
      ST_OFF    = 2'b00,
      ST_SETTLE = 2'b01,
      ST_RUN    = 2'b10,
      ST_DRAIN  = 2'b11
   } state_t;

   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SW-1:0]      SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [SW-1:0]      SETTLE_ONE  = SW'(1);
   localparam logic [PRESC_W-1:0] PRESC_ONE   = PRESC_W'(1);

   state_t              st;
   logic [SW-1:0]       settle_cnt;

   logic                led_on;
   logic [PRESC_W-1:0]  presc;
   logic [7:0]          duty    [3];
   logic [5:0]          cur     [3];
   logic [7:0]          duty_sh [3];
   logic [5:0]          cur_sh  [3];

   logic [PRESC_W-1:0]  presc_cnt;
   logic [7:0]          frame_cnt;

   logic                running;
   logic                tick;
   logic                frame_end;
   logic [2:0]          pwm_cmp;

   assign state     = st;
   assign cbit_rgb0 = cur_sh[0];
   assign cbit_rgb1 = cur_sh[1];
   assign cbit_rgb2 = cur_sh[2];

   // >= rather than == so shrinking PRESC below the live count ticks at once
   assign running   = (st == ST_RUN) || (st == ST_DRAIN);
   assign tick      = (presc_cnt >= presc);
   assign frame_end = running && tick && (frame_cnt == 8'hFF);

   always_comb begin
      pwm_cmp = '0;
      for (int n = 0; n < 3; n++) begin
         pwm_cmp[n] = (frame_cnt < duty_sh[n]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         led_on <= 1'b0;
         presc  <= '0;
         for (int n = 0; n < 3; n++) begin
            duty[n] <= '0;
            cur[n]  <= '0;
         end
      end else if (wr_en) begin
         case (wr_addr)
            4'h0: led_on  <= wr_data[0];
            4'h1: presc   <= PRESC_W'(wr_data);
            4'h2: duty[0] <= wr_data;
            4'h3: duty[1] <= wr_data;
            4'h4: duty[2] <= wr_data;
            4'h5: cur[0]  <= wr_data[5:0];
            4'h6: cur[1]  <= wr_data[5:0];
            4'h7: cur[2]  <= wr_data[5:0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st          <= ST_OFF;
         settle_cnt  <= '0;
         presc_cnt   <= '0;
         frame_cnt   <= '0;
         rgbled_en   <= 1'b0;
         cbit_rgb_en <= 1'b0;
         rgb_pwm     <= '0;
         ready       <= 1'b0;
         for (int n = 0; n < 3; n++) begin
            duty_sh[n] <= '0;
            cur_sh[n]  <= '0;
         end
      end else begin
         // Shadows see the register value from before this edge, so a write
         // landing on a boundary edge waits a full frame.
         if (!running || frame_end) begin
            for (int n = 0; n < 3; n++) begin
               duty_sh[n] <= duty[n];
               cur_sh[n]  <= cur[n];
            end
         end

         if (running) begin
            if (tick) begin
               presc_cnt <= '0;
               frame_cnt <= frame_cnt + 8'd1;
            end else begin
               presc_cnt <= presc_cnt + PRESC_ONE;
            end
         end else begin
            presc_cnt <= '0;
            frame_cnt <= '0;
         end

         case (st)
            ST_OFF: begin
               rgb_pwm <= '0;
               ready   <= 1'b0;
               if (led_on) begin
                  st          <= ST_SETTLE;
                  settle_cnt  <= '0;
                  rgbled_en   <= 1'b1;
                  cbit_rgb_en <= 1'b1;
               end else begin
                  rgbled_en   <= 1'b0;
                  cbit_rgb_en <= 1'b0;
               end
            end
            ST_SETTLE: begin
               rgb_pwm <= '0;
               if (!led_on) begin
                  st          <= ST_OFF;
                  rgbled_en   <= 1'b0;
                  cbit_rgb_en <= 1'b0;
               end else if (settle_cnt == SETTLE_LAST) begin
                  st    <= ST_RUN;
                  ready <= 1'b1;
               end else begin
                  settle_cnt <= settle_cnt + SETTLE_ONE;
               end
            end
            ST_RUN: begin
               rgb_pwm <= pwm_cmp;
               if (!led_on) begin
                  st    <= ST_DRAIN;
                  ready <= 1'b0;
               end
            end
            ST_DRAIN: begin
               if (led_on) begin
                  st      <= ST_RUN;
                  ready   <= 1'b1;
                  rgb_pwm <= pwm_cmp;
               end else if (frame_end) begin
                  st          <= ST_OFF;
                  rgb_pwm     <= '0;
                  rgbled_en   <= 1'b0;
                  cbit_rgb_en <= 1'b0;
               end else begin
                  rgb_pwm <= pwm_cmp;
               end
            end
            default: st <= ST_OFF;
         endcase
      end
   end

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// Testbench for rgb_pwm_ctrl: directed scenarios with arithmetic expectations
// plus a randomized run checked cycle by cycle against a behavioural model.

module tb_rgb_pwm_ctrl;

   localparam int SETTLE = 64;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_en = 1'b0;
   logic [3:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic       rgbled_en, cbit_rgb_en, ready;
   logic [2:0] rgb_pwm;
   logic [5:0] cbit_rgb0, cbit_rgb1, cbit_rgb2;
   logic [1:0] state;

   int total = 0;
   int bad   = 0;

   // behavioural model state
   int m_led, m_presc, m_st, m_settle, m_pc, m_fc, m_bias, m_ready;
   int m_duty [3];
   int m_cur  [3];
   int m_dsh  [3];
   int m_csh  [3];
   int m_pwm  [3];

   always #5 clk = ~clk;

   rgb_pwm_ctrl #(.SETTLE_CYCLES(SETTLE), .PRESC_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rgbled_en(rgbled_en), .cbit_rgb_en(cbit_rgb_en), .rgb_pwm(rgb_pwm),
      .cbit_rgb0(cbit_rgb0), .cbit_rgb1(cbit_rgb1), .cbit_rgb2(cbit_rgb2),
      .ready(ready), .state(state)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      step();
      wr_en = 1'b0;
   endtask

   task automatic hard_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (ready !== 1'b1 && n < 300) begin
         step();
         n++;
      end
   endtask

   task automatic test_reset();
      int n, cnt;
      hard_reset();
      wr(4'h2, 8'd128);
      wr(4'h0, 8'h01);
      wait_ready(n);
      total++; if (n >= 300) begin bad++; $display("FAIL rst_ready_timeout waited=%0d", n); end
      repeat (10) step();
      total++; if (rgb_pwm[0] !== 1'b1) begin bad++; $display("FAIL rst_pre_pwm got=%b exp=1", rgb_pwm[0]); end
      rst_n = 1'b0;
      step();
      total++;
      if ({state, ready, rgbled_en, cbit_rgb_en, rgb_pwm} !== 8'h00) begin
         bad++; $display("FAIL rst_outputs got=%h exp=00", {state, ready, rgbled_en, cbit_rgb_en, rgb_pwm});
      end
      total++;
      if ({cbit_rgb0, cbit_rgb1, cbit_rgb2} !== 18'h0) begin
         bad++; $display("FAIL rst_cbit got=%h exp=0", {cbit_rgb0, cbit_rgb1, cbit_rgb2});
      end
      step();
      rst_n = 1'b1;
      wr(4'h0, 8'h01);
      wait_ready(n);
      total++; if (state !== 2'b10) begin bad++; $display("FAIL rst_reenable_state got=%0d exp=2", state); end
      cnt = 0;
      for (int j = 0; j < 256; j++) begin
         step();
         if (rgb_pwm !== 3'b000) cnt++;
      end
      total++; if (cnt != 0) begin bad++; $display("FAIL rst_duty_cleared pwm_cycles=%0d exp=0", cnt); end
   endtask

   task automatic test_power_up();
      int cnt;
      bit early;
      hard_reset();
      wr(4'h1, 8'd0);
      wr(4'h5, 8'h01);
      wr(4'h2, 8'd64);
      wr(4'h0, 8'h01);
      total++; if (rgbled_en !== 1'b0) begin bad++; $display("FAIL pu_en_early got=%b exp=0", rgbled_en); end
      step();
      total++;
      if ({state, rgbled_en, cbit_rgb_en} !== 4'b0111) begin
         bad++; $display("FAIL pu_settle_entry got=%b exp=0111", {state, rgbled_en, cbit_rgb_en});
      end
      total++; if (cbit_rgb0 !== 6'h01) begin bad++; $display("FAIL pu_cbit0 got=%h exp=01", cbit_rgb0); end
      early = 1'b0; cnt = 0;
      for (int i = 1; i <= SETTLE; i++) begin
         step();
         if (rgb_pwm !== 3'b000) cnt++;
         if (i < SETTLE && ready !== 1'b0) early = 1'b1;
      end
      total++; if (cnt != 0) begin bad++; $display("FAIL pu_pwm_in_settle got=%0d exp=0", cnt); end
      total++; if (early) begin bad++; $display("FAIL pu_ready_early got=1 exp=0"); end
      total++;
      if ({ready, state} !== 3'b110) begin
         bad++; $display("FAIL pu_ready got=%b exp=110", {ready, state});
      end
      cnt = 0;
      for (int j = 1; j <= 512; j++) begin
         step();
         if (j == 1 && rgb_pwm[0] !== 1'b1) begin
            total++; bad++; $display("FAIL pu_first_pwm got=%b exp=1", rgb_pwm[0]);
         end
         if (rgb_pwm[0] === 1'b1) cnt++;
      end
      total++; if (cnt != 128) begin bad++; $display("FAIL pu_duty64 high=%0d exp=128", cnt); end
   endtask

   task automatic test_endpoints();
      int n, hi1, lo2;
      hard_reset();
      wr(4'h1, 8'd3);
      wr(4'h3, 8'd0);
      wr(4'h4, 8'd255);
      wr(4'h0, 8'h01);
      wait_ready(n);
      step();
      hi1 = 0; lo2 = 0;
      for (int j = 0; j < 2048; j++) begin
         step();
         if (rgb_pwm[1] === 1'b1) hi1++;
         if (rgb_pwm[2] !== 1'b1) lo2++;
      end
      total++; if (hi1 != 0) begin bad++; $display("FAIL ep_duty0 high=%0d exp=0", hi1); end
      total++; if (lo2 != 8) begin bad++; $display("FAIL ep_duty255 low=%0d exp=8", lo2); end
   endtask

   // Writes DUTY0=10 on edge (RUN entry + wj) with DUTY0 starting at 200,
   // and counts the high cycles of pwm[0] in each of three 256-clock frames.
   task automatic run_glitch(input int wj, input int e0, input int e1, input int e2);
      int n;
      int hc [3];
      hard_reset();
      wr(4'h1, 8'd0);
      wr(4'h2, 8'd200);
      wr(4'h0, 8'h01);
      wait_ready(n);
      hc[0] = 0; hc[1] = 0; hc[2] = 0;
      for (int j = 1; j <= 768; j++) begin
         if (j == wj) begin wr_en = 1'b1; wr_addr = 4'h2; wr_data = 8'd10; end
         step();
         wr_en = 1'b0;
         if (rgb_pwm[0] === 1'b1) hc[(j - 1) / 256]++;
      end
      total++; if (hc[0] != e0) begin bad++; $display("FAIL glitch_w%0d_f0 high=%0d exp=%0d", wj, hc[0], e0); end
      total++; if (hc[1] != e1) begin bad++; $display("FAIL glitch_w%0d_f1 high=%0d exp=%0d", wj, hc[1], e1); end
      total++; if (hc[2] != e2) begin bad++; $display("FAIL glitch_w%0d_f2 high=%0d exp=%0d", wj, hc[2], e2); end
   endtask

   task automatic test_glitch_free();
      run_glitch(101, 200, 10, 10);
      run_glitch(256, 200, 200, 10);
   endtask

   task automatic test_drain_abort();
      int n, hc;
      bit any_pwm;
      hard_reset();
      wr(4'h1, 8'd0);
      wr(4'h2, 8'd100);
      wr(4'h0, 8'h01);
      wait_ready(n);
      hc = 0;
      for (int j = 1; j <= 256; j++) begin
         if (j == 51) begin wr_en = 1'b1; wr_addr = 4'h0; wr_data = 8'h00; end
         step();
         wr_en = 1'b0;
         if (rgb_pwm[0] === 1'b1) hc++;
         if (j == 52) begin
            total++; if ({state, ready} !== 3'b110) begin bad++; $display("FAIL drain_entry got=%b exp=110", {state, ready}); end
         end
         if (j == 255) begin
            total++; if (state !== 2'b11) begin bad++; $display("FAIL drain_hold got=%0d exp=3", state); end
         end
      end
      total++; if (hc != 100) begin bad++; $display("FAIL drain_frame high=%0d exp=100", hc); end
      total++;
      if ({state, rgb_pwm, rgbled_en, cbit_rgb_en} !== 7'b0) begin
         bad++; $display("FAIL drain_off got=%b exp=0000000", {state, rgb_pwm, rgbled_en, cbit_rgb_en});
      end
      // re-enable from DRAIN skips SETTLE
      wr(4'h0, 8'h01);
      wait_ready(n);
      wr(4'h0, 8'h00);
      step();
      wr(4'h0, 8'h01);
      total++; if (state !== 2'b11) begin bad++; $display("FAIL rerun_in_drain got=%0d exp=3", state); end
      step();
      total++; if ({state, ready} !== 3'b101) begin bad++; $display("FAIL rerun_run got=%b exp=101", {state, ready}); end
      // abort mid-SETTLE
      hard_reset();
      wr(4'h2, 8'd255);
      wr(4'h0, 8'h01);
      any_pwm = 1'b0;
      repeat (20) begin step(); if (rgb_pwm !== 3'b000) any_pwm = 1'b1; end
      total++; if (state !== 2'b01) begin bad++; $display("FAIL abort_settle got=%0d exp=1", state); end
      wr(4'h0, 8'h00);
      step();
      total++; if ({state, rgbled_en} !== 3'b000) begin bad++; $display("FAIL abort_off got=%b exp=000", {state, rgbled_en}); end
      repeat (100) begin step(); if (rgb_pwm !== 3'b000) any_pwm = 1'b1; end
      total++; if (any_pwm) begin bad++; $display("FAIL abort_pwm got=1 exp=0"); end
   endtask

   task automatic test_presc_shrink();
      int n, hc, last;
      hard_reset();
      wr(4'h1, 8'd200);
      wr(4'h2, 8'd3);
      wr(4'h0, 8'h01);
      wait_ready(n);
      hc = 0; last = 0;
      for (int j = 1; j <= 400; j++) begin
         if (j == 150) begin wr_en = 1'b1; wr_addr = 4'h1; wr_data = 8'd10; end
         step();
         wr_en = 1'b0;
         if (rgb_pwm[0] === 1'b1) begin hc++; last = j; end
      end
      total++; if (hc != 173) begin bad++; $display("FAIL presc_shrink high=%0d exp=173", hc); end
      total++; if (last != 173) begin bad++; $display("FAIL presc_shrink_last got=%0d exp=173", last); end
   endtask

   task automatic model_reset();
      m_led = 0; m_presc = 0; m_st = 0; m_settle = 0; m_pc = 0; m_fc = 0;
      m_bias = 0; m_ready = 0;
      for (int n = 0; n < 3; n++) begin
         m_duty[n] = 0; m_cur[n] = 0; m_dsh[n] = 0; m_csh[n] = 0; m_pwm[n] = 0;
      end
   endtask

   // One clock of the controller, described from the register/frame rules.
   task automatic model_step(input bit we, input int wa, input int wd);
      bit tk, run, fend;
      int nst;
      tk   = (m_pc >= m_presc);
      run  = (m_st == 2 || m_st == 3);
      fend = run && tk && (m_fc == 255);
      case (m_st)
         0:       nst = m_led ? 1 : 0;
         1:       nst = !m_led ? 0 : ((m_settle == SETTLE - 1) ? 2 : 1);
         2:       nst = m_led ? 2 : 3;
         default: nst = m_led ? 2 : (fend ? 0 : 3);
      endcase
      for (int n = 0; n < 3; n++)
         m_pwm[n] = ((m_st == 2) || (m_st == 3 && nst != 0)) ? int'(m_fc < m_dsh[n]) : 0;
      if (m_st == 0) m_settle = 0;
      else if (m_st == 1 && nst == 1) m_settle++;
      if (!run || fend)
         for (int n = 0; n < 3; n++) begin m_dsh[n] = m_duty[n]; m_csh[n] = m_cur[n]; end
      if (run) begin
         if (tk) begin m_pc = 0; m_fc = (m_fc + 1) % 256; end
         else m_pc++;
      end else begin
         m_pc = 0; m_fc = 0;
      end
      m_st    = nst;
      m_bias  = (nst != 0);
      m_ready = (nst == 2);
      if (we) begin
         case (wa)
            0:       m_led = wd % 2;
            1:       m_presc = wd % 256;
            2, 3, 4: m_duty[wa - 2] = wd;
            5, 6, 7: m_cur[wa - 5] = wd % 64;
            default: ;
         endcase
      end
   endtask

   task automatic test_random();
      int r, a, d, shown;
      bit we;
      logic [7:0] exp_ctl;
      logic [17:0] exp_cb;
      shown = 0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      model_reset();
      for (int c = 0; c < 12000; c++) begin
         r = $urandom_range(0, 63);
         we = 1'b1;
         if (r < 6) begin a = $urandom_range(2, 7); d = $urandom_range(0, 255); end
         else if (r == 6) begin a = 1; d = $urandom_range(0, 2); end
         else if (r == 7 && $urandom_range(0, 9) == 0) begin a = 0; d = $urandom_range(0, 255); end
         else if (r == 8) begin a = $urandom_range(8, 15); d = $urandom_range(0, 255); end
         else begin we = 1'b0; a = 0; d = 0; end
         if (c == 5) begin we = 1'b1; a = 0; d = 1; end
         wr_en = we; wr_addr = 4'(a); wr_data = 8'(d);
         model_step(we, a, d);
         step();
         wr_en = 1'b0;
         exp_ctl = {2'(m_st), 1'(m_ready), 1'(m_bias), 1'(m_bias),
                    1'(m_pwm[2]), 1'(m_pwm[1]), 1'(m_pwm[0])};
         exp_cb  = {6'(m_csh[0]), 6'(m_csh[1]), 6'(m_csh[2])};
         total++;
         if ({state, ready, rgbled_en, cbit_rgb_en, rgb_pwm} !== exp_ctl) begin
            bad++;
            if (shown < 10) $display("FAIL rand_ctl cyc=%0d got=%b exp=%b", c,
                                     {state, ready, rgbled_en, cbit_rgb_en, rgb_pwm}, exp_ctl);
            shown++;
         end
         total++;
         if ({cbit_rgb0, cbit_rgb1, cbit_rgb2} !== exp_cb) begin
            bad++;
            if (shown < 10) $display("FAIL rand_cbit cyc=%0d got=%h exp=%h", c,
                                     {cbit_rgb0, cbit_rgb1, cbit_rgb2}, exp_cb);
            shown++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_power_up();
      test_endpoints();
      test_glitch_free();
      test_drain_abort();
      test_presc_shrink();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
